// File: rtl/fpga_uart_pkg.sv
// +-----------------------------------------------------------------------+
// | fpga_uart_pkg : shared types for the tinyQV UART receive path          |
// | rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

package fpga_uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef logic [UART_DATA_BITS-1:0] byte_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_byte_fifo.sv
// +-----------------------------------------------------------------------+
// | uart_byte_fifo : first-word-fall-through byte FIFO with wrap-bit ptrs  |
// | rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module uart_byte_fifo
    import fpga_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              push,
    input  logic [UART_DATA_BITS-1:0]         push_data,
    input  logic                              pop,
    output logic [UART_DATA_BITS-1:0]         pop_data,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    byte_t       mem_q [FIFO_DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign count    = wr_ptr_q - rd_ptr_q;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tinyqv_uart_rx_capture.sv
// +-----------------------------------------------------------------------+
// | tinyqv_uart_rx_capture : 8N1 receiver for the tinyQV TX pin, buffered  |
// | rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module tinyqv_uart_rx_capture
    import fpga_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              uart_rxd,
    output logic [UART_DATA_BITS-1:0]         rx_data,
    output logic                              rx_valid,
    input  logic                              rx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   rx_count,
    output logic                              frame_err,
    output logic                              overflow,
    input  logic                              clear_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(UART_DATA_BITS);
    // Counters run down to zero, so a load of N-1 expires after N cycles.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT/2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(UART_DATA_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    rx_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_idx_q, bit_idx_d;
    byte_t                  shreg_q, shreg_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overflow_q, overflow_d;
    logic                   rxs;
    logic                   tick;
    logic                   push;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], uart_rxd};
    assign rxs    = sync_q[SYNC_STAGES-1];
    assign tick   = (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end
            end
            START: begin
                if (!tick) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (!rxs) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    cnt_d     = FULL_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    shreg_d = {rxs, shreg_q[UART_DATA_BITS-1:1]};
                    cnt_d   = FULL_LOAD;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_ONE;
                    end
                end
            end
            STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (rxs) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = BREAK;
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear wins over a drop in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (clear_err) begin
            overflow_d = 1'b0;
        end else if (push && fifo_full && !(rx_valid && rx_ready)) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    uart_byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (shreg_d),
        .pop       (rx_ready),
        .pop_data  (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (rx_count)
    );

    assign rx_valid  = ~fifo_empty;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_tinyqv_uart_rx_capture.sv
// +-----------------------------------------------------------------------+
// | tb_tinyqv_uart_rx_capture : scoreboard bench for the UART RX capture   |
// | rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_tinyqv_uart_rx_capture;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH+1);
    localparam int FRAME = 10 * CPB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          uart_rxd;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [CW-1:0] rx_count;
    logic          frame_err;
    logic          overflow;
    logic          clear_err;

    int         n_checks = 0;
    int         n_errors = 0;
    int         fe_count = 0;
    int         fe0;
    logic [7:0] sb_q [$];

    always #5 clk = ~clk;

    tinyqv_uart_rx_capture #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .SYNC_STAGES  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rxd  (uart_rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_count  (rx_count),
        .frame_err (frame_err),
        .overflow  (overflow),
        .clear_err (clear_err)
    );

    always @(posedge clk) begin
        #1;
        if (frame_err === 1'b1) fe_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame bit-by-bit; n_cycles < FRAME truncates it mid-frame.
    task automatic send_frame(input logic [7:0] data, input logic stop,
                              input logic pop_at_stop, input int n_cycles);
        logic [9:0] bits;
        logic       pre_empty;
        bits      = {stop, data, 1'b0};
        pre_empty = (sb_q.size() == 0);
        if (stop && n_cycles == FRAME && (pop_at_stop || sb_q.size() < DEPTH))
            sb_q.push_back(data);
        for (int i = 0; i < n_cycles; i++) begin
            @(negedge clk);
            uart_rxd = bits[i/CPB];
            if (i == 9*CPB && pre_empty && stop)
                check("valid_before_stop", {31'd0, rx_valid}, 32'd0);
            // Stop bit is sampled on the posedge following drive cycle 154.
            if (pop_at_stop && i == 154) begin
                check("popush_valid", {31'd0, rx_valid}, 32'd1);
                check("popush_data", {24'd0, rx_data}, {24'd0, sb_q.pop_front()});
                rx_ready = 1'b1;
            end
            if (pop_at_stop && i == 155) rx_ready = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] data);
        send_frame(data, 1'b1, 1'b0, FRAME);
        idle(16);
    endtask

    task automatic pop_one(input string tag);
        @(negedge clk);
        check({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
        if (sb_q.size() > 0)
            check({tag, "_data"}, {24'd0, rx_data}, {24'd0, sb_q.pop_front()});
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        uart_rxd  = 1'b1;
        rx_ready  = 1'b0;
        clear_err = 1'b0;
        idle(3);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_count", 32'(rx_count), 32'd0);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        idle(4);

        // Single byte, consumer stalled.
        send_frame(8'h55, 1'b1, 1'b0, FRAME);
        check("t1_valid", {31'd0, rx_valid}, 32'd1);
        check("t1_data", {24'd0, rx_data}, {24'd0, sb_q[0]});
        check("t1_count", 32'(rx_count), 32'(sb_q.size()));
        idle(16);

        // Short low glitch is rejected.
        fe0      = fe_count;
        uart_rxd = 1'b0;
        idle(4);
        uart_rxd = 1'b1;
        idle(40);
        check("t2_count", 32'(rx_count), 32'(sb_q.size()));
        check("t2_ferr", 32'(fe_count - fe0), 32'd0);
        check("t2_data_hold", {24'd0, rx_data}, 32'h55);

        // Framing error followed by a held-low line, then a good frame.
        fe0 = fe_count;
        send_frame(8'hA5, 1'b0, 1'b0, FRAME);
        idle(40);
        uart_rxd = 1'b1;
        idle(32);
        check("t3_ferr", 32'(fe_count - fe0), 32'd1);
        check("t3_count", 32'(rx_count), 32'(sb_q.size()));
        send_byte(8'h3C);
        check("t3_count2", 32'(rx_count), 32'(sb_q.size()));
        while (sb_q.size() > 0) pop_one("t3_drain");
        @(negedge clk);
        check("t3_empty", {31'd0, rx_valid}, 32'd0);

        // Overflow: nine bytes into an eight-entry FIFO.
        for (int b = 0; b <= 8; b++) send_byte(8'(b));
        check("t4_count", 32'(rx_count), 32'd8);
        check("t4_ovf", {31'd0, overflow}, 32'd1);
        while (sb_q.size() > 0) pop_one("t4_drain");
        @(negedge clk);
        check("t4_empty", {31'd0, rx_valid}, 32'd0);
        check("t4_count0", 32'(rx_count), 32'd0);
        check("t4_ovf_sticky", {31'd0, overflow}, 32'd1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check("t4_ovf_clr", {31'd0, overflow}, 32'd0);

        // Full FIFO: push and pop land on the same edge.
        for (int b = 8'h10; b <= 8'h17; b++) send_byte(8'(b));
        check("t5_full", 32'(rx_count), 32'd8);
        send_frame(8'h18, 1'b1, 1'b1, FRAME);
        idle(16);
        check("t5_count", 32'(rx_count), 32'd8);
        check("t5_ovf", {31'd0, overflow}, 32'd0);
        check("t5_head", {24'd0, rx_data}, {24'd0, sb_q[0]});
        send_byte(8'h99);
        check("t5_drop_ovf", {31'd0, overflow}, 32'd1);
        check("t5_drop_count", 32'(rx_count), 32'd8);
        check("t5_drop_head", {24'd0, rx_data}, {24'd0, sb_q[0]});

        // Reset in the middle of data bit 3.
        send_frame(8'hC3, 1'b1, 1'b0, 4*CPB + 8);
        rst_n    = 1'b0;
        uart_rxd = 1'b1;
        @(negedge clk);
        check("t6_valid", {31'd0, rx_valid}, 32'd0);
        check("t6_count", 32'(rx_count), 32'd0);
        check("t6_data", {24'd0, rx_data}, 32'd0);
        check("t6_ferr", {31'd0, frame_err}, 32'd0);
        check("t6_ovf", {31'd0, overflow}, 32'd0);
        sb_q.delete();
        idle(2);
        rst_n = 1'b1;
        idle(16);
        send_byte(8'hC3);
        check("t6_count1", 32'(rx_count), 32'd1);
        pop_one("t6_pop");
        @(negedge clk);
        check("t6_empty", {31'd0, rx_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
